// File: rtl/aes_key_mem_mctx.sv
`default_nettype none
// ============================================================================
//  Module   : aes_key_mem_mctx
//  Brief    : Word-serial AES-128/192/256 key expansion with a multi-context
//             round-key store and a shared, optionally pipelined, S-box port.
//  Revision : 1.0
// ============================================================================
module aes_key_mem_mctx #(
  parameter int NUM_CTX  = 2,
  parameter int CTX_W    = 1,
  parameter int SBOX_LAT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init,
  input  logic [CTX_W-1:0]   init_ctx,
  input  logic [1:0]         keylen,
  input  logic [255:0]       key,
  input  logic [CTX_W-1:0]   rd_ctx,
  input  logic [3:0]         round,
  output logic [127:0]       round_key,
  output logic [NUM_CTX-1:0] ready,
  output logic               busy,
  output logic               err,
  output logic [31:0]        sboxw,
  input  logic [31:0]        new_sboxw
);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_load  = 3'd1;
  localparam logic [2:0] c_st_gen   = 3'd2;
  localparam logic [2:0] c_st_swait = 3'd3;
  localparam logic [2:0] c_st_done  = 3'd4;
  localparam logic [1:0] c_wait_init = 2'((SBOX_LAT > 0) ? SBOX_LAT - 1 : 0);

  logic [2:0]         r_state;
  logic [255:0]       r_key;
  logic [1:0]         r_klen;
  logic [CTX_W-1:0]   r_ctx;
  logic [7:0]         r_rcon;
  logic [5:0]         r_i;
  logic [2:0]         r_mod;
  logic [1:0]         r_wcnt;
  logic [31:0]        r_win [8];
  logic [31:0]        r_mem [NUM_CTX][60];
  logic [1:0]         r_ctx_klen [NUM_CTX];
  logic [NUM_CTX-1:0] r_ready;
  logic               r_busy;
  logic               r_err;

  logic [3:0]   w_nk;
  logic [5:0]   w_last;
  logic [7:0]   w_kshift;
  logic [31:0]  w_prev_nk;
  logic [255:0] w_kwin;
  logic         w_rcon_word;
  logic         w_sbox_word;
  logic         w_commit;
  logic         w_ctx_ok;
  logic [31:0]  w_new;
  logic [3:0]   w_rd_nr;
  logic [5:0]   w_rd_base;

  // Window holds w[i-8..i-1] with w[i-1] in slot 7, so w[i-Nk] sits at 8-Nk.
  always_comb begin
    case (r_klen)
      2'd1:    begin w_nk = 4'd6; w_last = 6'd51; w_kshift = 8'd64;  w_prev_nk = r_win[2]; end
      2'd2:    begin w_nk = 4'd8; w_last = 6'd59; w_kshift = 8'd0;   w_prev_nk = r_win[0]; end
      default: begin w_nk = 4'd4; w_last = 6'd43; w_kshift = 8'd128; w_prev_nk = r_win[4]; end
    endcase
  end

  assign w_kwin      = r_key >> w_kshift;
  assign w_rcon_word = (r_mod == 3'd0);
  assign w_sbox_word = w_rcon_word || ((r_klen == 2'd2) && (r_mod == 3'd4));
  assign w_ctx_ok    = int'(r_ctx) < NUM_CTX;
  assign w_commit    = ((r_state == c_st_gen) && (!w_sbox_word || (SBOX_LAT == 0))) ||
                       ((r_state == c_st_swait) && (r_wcnt == 2'd0));

  always_comb begin
    if (w_rcon_word)
      w_new = w_prev_nk ^ {new_sboxw[23:0], new_sboxw[31:24]} ^ {r_rcon, 24'h0};
    else if (w_sbox_word)
      w_new = w_prev_nk ^ new_sboxw;
    else
      w_new = w_prev_nk ^ r_win[7];
  end

  assign sboxw = ((r_state == c_st_gen) || (r_state == c_st_swait)) ? r_win[7] : 32'h0;
  assign ready = r_ready;
  assign busy  = r_busy;
  assign err   = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
      r_key   <= '0;
      r_klen  <= '0;
      r_ctx   <= '0;
      r_rcon  <= 8'h01;
      r_i     <= '0;
      r_mod   <= '0;
      r_wcnt  <= '0;
      r_ready <= '0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      for (int j = 0; j < 8; j++) r_win[j] <= '0;
      for (int c = 0; c < NUM_CTX; c++) begin
        r_ctx_klen[c] <= '0;
        for (int w = 0; w < 60; w++) r_mem[c][w] <= '0;
      end
    end else begin
      r_err <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (init) begin
            if (keylen == 2'd3) begin
              r_err <= 1'b1;
            end else begin
              r_key  <= key;
              r_klen <= keylen;
              r_ctx  <= init_ctx;
              if (int'(init_ctx) < NUM_CTX) r_ready[init_ctx] <= 1'b0;
              r_busy  <= 1'b1;
              r_rcon  <= 8'h01;
              r_state <= c_st_load;
            end
          end
        end
        c_st_load: begin
          for (int k = 0; k < 8; k++) begin
            r_win[k] <= w_kwin[255-32*k -: 32];
            if (w_ctx_ok && (k < int'(w_nk))) r_mem[r_ctx][k] <= r_key[255-32*k -: 32];
          end
          r_i     <= 6'(w_nk);
          r_mod   <= 3'd0;
          r_state <= c_st_gen;
        end
        c_st_gen: begin
          if (!w_commit) begin
            r_wcnt  <= c_wait_init;
            r_state <= c_st_swait;
          end
        end
        c_st_swait: begin
          if (r_wcnt != 2'd0) r_wcnt <= r_wcnt - 2'd1;
        end
        c_st_done: begin
          if (w_ctx_ok) begin
            r_ready[r_ctx]    <= 1'b1;
            r_ctx_klen[r_ctx] <= r_klen;
          end
          r_busy  <= 1'b0;
          r_state <= c_st_idle;
        end
        default: r_state <= c_st_idle;
      endcase

      if (w_commit) begin
        if (w_ctx_ok) r_mem[r_ctx][r_i] <= w_new;
        for (int j = 0; j < 7; j++) r_win[j] <= r_win[j+1];
        r_win[7] <= w_new;
        if (w_rcon_word) r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
        r_i     <= r_i + 6'd1;
        r_mod   <= (r_mod == 3'(w_nk - 4'd1)) ? 3'd0 : r_mod + 3'd1;
        r_state <= (r_i == w_last) ? c_st_done : c_st_gen;
      end
    end
  end

  // Rounds beyond the stored key length of the context read as zero.
  assign w_rd_base = {round, 2'b00};
  always_comb begin
    w_rd_nr   = 4'd10;
    round_key = '0;
    if (int'(rd_ctx) < NUM_CTX) begin
      case (r_ctx_klen[rd_ctx])
        2'd1:    w_rd_nr = 4'd12;
        2'd2:    w_rd_nr = 4'd14;
        default: w_rd_nr = 4'd10;
      endcase
      if (round <= w_rd_nr)
        round_key = {r_mem[rd_ctx][w_rd_base],         r_mem[rd_ctx][w_rd_base + 6'd1],
                     r_mem[rd_ctx][w_rd_base + 6'd2],  r_mem[rd_ctx][w_rd_base + 6'd3]};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_mem_mctx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_key_mem_mctx
//  Brief    : Two instances (S-box latency 0 and 2) driven in lockstep and
//             compared against a FIPS-197 style key schedule model.
//  Revision : 1.0
// ============================================================================
module tb_aes_key_mem_mctx;

  logic         clk = 1'b0;
  logic         reset;
  logic         init;
  logic [0:0]   init_ctx;
  logic [1:0]   keylen;
  logic [255:0] key;
  logic [0:0]   rd_ctx;
  logic [3:0]   round;

  logic [127:0] rk0, rk2;
  logic [1:0]   rdy0, rdy2;
  logic         busy0, busy2, err0, err2;
  logic [31:0]  sbw0, sbw2, nsb0, nsb2, s1_2;

  logic [7:0]   sbox_tab [256];
  logic [31:0]  exp_mem [2][60];
  int           exp_klen [2];
  logic [1:0]   exp_ready;
  int           exp_lat0, exp_lat2, got_lat0, got_lat2;
  int           n_checks = 0;
  int           n_errors = 0;

  localparam logic [255:0] c_key128 = {128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 128'h0};
  localparam logic [255:0] c_key192 = {192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b, 64'h0};
  localparam logic [255:0] c_key256 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

  always #5 clk = ~clk;

  aes_key_mem_mctx #(.NUM_CTX(2), .CTX_W(1), .SBOX_LAT(0)) u_dut0 (
    .clk(clk), .reset(reset), .init(init), .init_ctx(init_ctx), .keylen(keylen), .key(key),
    .rd_ctx(rd_ctx), .round(round), .round_key(rk0), .ready(rdy0), .busy(busy0), .err(err0),
    .sboxw(sbw0), .new_sboxw(nsb0)
  );

  aes_key_mem_mctx #(.NUM_CTX(2), .CTX_W(1), .SBOX_LAT(2)) u_dut2 (
    .clk(clk), .reset(reset), .init(init), .init_ctx(init_ctx), .keylen(keylen), .key(key),
    .rd_ctx(rd_ctx), .round(round), .round_key(rk2), .ready(rdy2), .busy(busy2), .err(err2),
    .sboxw(sbw2), .new_sboxw(nsb2)
  );

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  assign nsb0 = {sbox_tab[sbw0[31:24]], sbox_tab[sbw0[23:16]], sbox_tab[sbw0[15:8]], sbox_tab[sbw0[7:0]]};
  always @(posedge clk) begin
    s1_2 <= subword(sbw2);
    nsb2 <= s1_2;
  end

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h0;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
      if (x == 0) inv = 8'h00;
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      exp_klen[c] = 0;
      for (int i = 0; i < 60; i++) exp_mem[c][i] = 32'h0;
    end
    exp_ready = 2'b00;
  endtask

  // FIPS-197 key expansion; words past T keep whatever the context held.
  task automatic model_expand(input int ctx, input logic [255:0] k, input int kl);
    int nk, t, nsb;
    logic [31:0] tmp;
    logic [7:0] rc;
    nk = 4 + 2 * kl;
    t = 4 * (nk + 7);
    rc = 8'h01;
    nsb = 0;
    for (int i = 0; i < nk; i++) exp_mem[ctx][i] = k[255-32*i -: 32];
    for (int i = nk; i < t; i++) begin
      tmp = exp_mem[ctx][i-1];
      if (i % nk == 0) begin
        tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
        nsb++;
      end else if (nk == 8 && i % 8 == 4) begin
        tmp = subword(tmp);
        nsb++;
      end
      exp_mem[ctx][i] = exp_mem[ctx][i-nk] ^ tmp;
    end
    exp_klen[ctx] = kl;
    exp_ready[ctx] = 1'b1;
    exp_lat0 = t - nk + 2;
    exp_lat2 = exp_lat0 + 2 * nsb;
  endtask

  function automatic logic [127:0] model_rk(input int ctx, input int r);
    if (r > 10 + 2 * exp_klen[ctx]) return 128'h0;
    return {exp_mem[ctx][4*r], exp_mem[ctx][4*r+1], exp_mem[ctx][4*r+2], exp_mem[ctx][4*r+3]};
  endfunction

  task automatic check_reads();
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < 16; r++) begin
        rd_ctx = 1'(c);
        round  = 4'(r);
        #1;
        check($sformatf("rk0 c%0d r%0d", c, r), rk0, model_rk(c, r));
        check($sformatf("rk2 c%0d r%0d", c, r), rk2, model_rk(c, r));
      end
    end
  endtask

  task automatic read_rk(input int c, input int r);
    rd_ctx = 1'(c);
    round  = 4'(r);
    #1;
  endtask

  // Starts an expansion and measures ready latency on both instances; when
  // watching, another context is read every cycle and junk inits are issued.
  task automatic run_init(input int kl, input logic [255:0] k, input int ctx,
                          input bit watch, input int wctx, input int wround);
    int n;
    logic err_seen;
    logic [127:0] wexp;
    wexp = model_rk(wctx, wround);
    @(negedge clk);
    key = k; keylen = 2'(kl); init_ctx = 1'(ctx); init = 1'b1;
    if (watch) begin rd_ctx = 1'(wctx); round = 4'(wround); end
    @(posedge clk); #1;
    init = 1'b0;
    n = 0;
    check("busy0 start", 128'(busy0), 128'(1));
    check("busy2 start", 128'(busy2), 128'(1));
    check("rdy0 cleared", 128'(rdy0[ctx]), 128'(0));
    check("rdy2 cleared", 128'(rdy2[ctx]), 128'(0));
    got_lat0 = -1; got_lat2 = -1; err_seen = 1'b0;
    while ((got_lat0 < 0 || got_lat2 < 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (got_lat0 < 0 && rdy0[ctx]) got_lat0 = n;
      if (got_lat2 < 0 && rdy2[ctx]) got_lat2 = n;
      err_seen = err_seen | err0 | err2;
      if (watch) begin
        check("watch rk0", rk0, wexp);
        check("watch rk2", rk2, wexp);
        if (n >= 5 && n <= 7) begin
          init = 1'b1; keylen = (n == 6) ? 2'd3 : 2'd0; init_ctx = 1'(wctx);
          key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        end else begin
          init = 1'b0;
        end
      end
    end
    init = 1'b0;
    model_expand(ctx, k, kl);
    check("latency dut0", 128'(got_lat0), 128'(exp_lat0));
    check("latency dut2", 128'(got_lat2), 128'(exp_lat2));
    check("busy0 end", 128'(busy0), 128'(0));
    check("busy2 end", 128'(busy2), 128'(0));
    check("err during busy", 128'(err_seen), 128'(0));
    check("ready0 vec", 128'(rdy0), 128'(exp_ready));
    check("ready2 vec", 128'(rdy2), 128'(exp_ready));
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; init_ctx = '0; keylen = '0; key = '0; rd_ctx = '0; round = '0;
    build_sbox();
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset ready0", 128'(rdy0), 128'(0));
    check("reset ready2", 128'(rdy2), 128'(0));
    check("reset busy0", 128'(busy0), 128'(0));
    check("reset err0", 128'(err0), 128'(0));
    check("reset sboxw0", 128'(sbw0), 128'(0));
    check_reads();

    // AES-128 known-answer vector into context 0
    run_init(0, c_key128, 0, 1'b0, 1, 0);
    check("aes128 lat const", 128'(got_lat0), 128'(42));
    read_rk(0, 1);
    check("aes128 r1 dut0", rk0, 128'ha0fafe17_88542cb1_23a33939_2a6c7605);
    check("aes128 r1 dut2", rk2, 128'ha0fafe17_88542cb1_23a33939_2a6c7605);
    read_rk(0, 10);
    check("aes128 r10 dut0", rk0, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
    check("aes128 r10 dut2", rk2, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
    read_rk(0, 11);
    check("aes128 r11 zero", rk0, 128'h0);
    check_reads();

    // AES-192 into context 1
    run_init(1, c_key192, 1, 1'b0, 0, 0);
    check("aes192 lat const", 128'(got_lat0), 128'(48));
    read_rk(1, 12);
    check("aes192 r12 dut0", rk0, 128'he98ba06f_448c773c_8ecc7204_01002202);
    check("aes192 r12 dut2", rk2, 128'he98ba06f_448c773c_8ecc7204_01002202);

    // AES-256 re-init of context 1 while context 0 is watched
    run_init(2, c_key256, 1, 1'b1, 0, 10);
    check("aes256 lat2 const", 128'(got_lat2), 128'(80));
    read_rk(1, 14);
    check("aes256 r14 dut0", rk0, 128'hfe4890d1_e6188d0b_046df344_706c631e);
    check("aes256 r14 dut2", rk2, 128'hfe4890d1_e6188d0b_046df344_706c631e);
    check_reads();

    // Illegal key length in IDLE
    @(negedge clk);
    keylen = 2'd3; init = 1'b1; init_ctx = 1'b0; key = {8{$urandom}};
    @(posedge clk); #1;
    init = 1'b0;
    check("err0 pulse", 128'(err0), 128'(1));
    check("err2 pulse", 128'(err2), 128'(1));
    check("err busy0", 128'(busy0), 128'(0));
    check("err ready0", 128'(rdy0), 128'(exp_ready));
    check("err ready2", 128'(rdy2), 128'(exp_ready));
    @(posedge clk); #1;
    check("err0 drop", 128'(err0), 128'(0));
    check("err2 drop", 128'(err2), 128'(0));
    check_reads();

    // Randomized expansions, always watching the other context
    for (int it = 0; it < 6; it++) begin
      int kl, cx;
      logic [255:0] rk;
      kl = int'($urandom_range(0, 2));
      cx = int'($urandom_range(0, 1));
      rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_init(kl, rk, cx, 1'b1, 1 - cx, int'($urandom_range(0, 10)));
      check_reads();
    end

    // Reset in the middle of generation
    @(negedge clk);
    key = c_key192; keylen = 2'd1; init_ctx = 1'b1; init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    model_clear();
    check("midreset busy0", 128'(busy0), 128'(0));
    check("midreset busy2", 128'(busy2), 128'(0));
    check("midreset ready0", 128'(rdy0), 128'(0));
    check("midreset ready2", 128'(rdy2), 128'(0));
    check("midreset sboxw2", 128'(sbw2), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    check_reads();
    run_init(0, c_key128, 0, 1'b0, 1, 0);
    read_rk(0, 10);
    check("post-reset r10 dut0", rk0, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
    check("post-reset r10 dut2", rk2, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
    check_reads();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
